// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl: CIC decimator sequencer with strobe generation, flush/settle rate changes and a 2-entry output queue
module cic_decim_ctrl #(
  parameter int OSZ            = 24,
  parameter int RATE_W         = 16,
  parameter int MIN_RATE       = 4,
  parameter int DEFAULT_RATE   = 64,
  parameter int FLUSH_CYCLES   = 8,
  parameter int SETTLE_OUTPUTS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              rate_wr,
  input  logic [RATE_W-1:0] rate,
  output logic [RATE_W-1:0] rate_cur,
  output logic              cic_reset,
  output logic              cic_out_clk,
  input  logic [OSZ-1:0]    cic_data,
  input  logic              cic_valid,
  output logic [OSZ-1:0]    m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              overrun,
  input  logic              ovr_clr
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_OUTPUTS + 1);
  typedef enum logic [1:0] {IDLE, FLUSH, SETTLE, RUN} state_t;
  state_t state_q, state_d;
  logic [RATE_W-1:0] pending_q, pending_d, rate_cur_q, rate_cur_d, cnt_q, cnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [OSZ-1:0] hold_q, hold_d, d0_q, d0_d, d1_q, d1_d;
  logic [1:0] n_q, n_d;
  logic rchg_q, rchg_d, vld_q, vld_d, ovr_q, ovr_d;
  logic live, wrap, commit, go_flush, push, pop;
  always_comb begin
    pending_d  = !rate_wr ? pending_q : (rate < RATE_W'(MIN_RATE)) ? RATE_W'(MIN_RATE) : rate;
    live       = state_q == SETTLE || state_q == RUN;
    wrap       = cnt_q == rate_cur_q - RATE_W'(1);
    commit     = live && vld_q && !cic_valid;
    hold_d     = cic_valid ? cic_data : hold_q;
    vld_d      = live && cic_valid;
    state_d    = state_q;
    rate_cur_d = (state_q == IDLE && rate_wr) ? pending_d : rate_cur_q;
    fcnt_d     = fcnt_q;
    scnt_d     = scnt_q;
    rchg_d     = rchg_q;
    go_flush   = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      rchg_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: go_flush = 1'b1;
        FLUSH: begin
          if (rate_wr) go_flush = 1'b1;
          else if (fcnt_q == FW'(FLUSH_CYCLES - 1)) begin
            state_d = SETTLE;
            scnt_d  = '0;
          end else fcnt_d = fcnt_q + FW'(1);
        end
        SETTLE: begin
          if (rate_wr) go_flush = 1'b1;
          else if (commit) begin
            if (scnt_q == SW'(SETTLE_OUTPUTS - 1)) state_d = RUN;
            else scnt_d = scnt_q + SW'(1);
          end
        end
        default: begin
          go_flush = (rchg_q || rate_wr) && wrap;
          rchg_d   = rchg_q || rate_wr;
        end
      endcase
    end
    if (go_flush) begin
      state_d    = FLUSH;
      fcnt_d     = '0;
      rate_cur_d = pending_d;
      rchg_d     = 1'b0;
    end
    cnt_d = (live && (state_d == SETTLE || state_d == RUN) && !wrap) ? cnt_q + RATE_W'(1) : '0;
    pop   = n_q != 2'd0 && m_ready;
    push  = commit && state_q == RUN;
    d0_d  = d0_q;
    d1_d  = d1_q;
    n_d   = n_q;
    ovr_d = ovr_clr ? 1'b0 : ovr_q;
    if (!enable) n_d = 2'd0;
    else begin
      if (pop) begin
        d0_d = d1_q;
        n_d  = n_q - 2'd1;
      end
      if (push) begin
        if (n_d == 2'd0) begin
          d0_d = hold_q;
          n_d  = 2'd1;
        end else if (n_d == 2'd1) begin
          d1_d = hold_q;
          n_d  = 2'd2;
        end else ovr_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pending_q  <= RATE_W'(DEFAULT_RATE);
      rate_cur_q <= RATE_W'(DEFAULT_RATE);
      cnt_q      <= '0;
      fcnt_q     <= '0;
      scnt_q     <= '0;
      hold_q     <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      n_q        <= 2'd0;
      rchg_q     <= 1'b0;
      vld_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      rate_cur_q <= rate_cur_d;
      cnt_q      <= cnt_d;
      fcnt_q     <= fcnt_d;
      scnt_q     <= scnt_d;
      hold_q     <= hold_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      n_q        <= n_d;
      rchg_q     <= rchg_d;
      vld_q      <= vld_d;
      ovr_q      <= ovr_d;
    end
  end
  assign rate_cur    = rate_cur_q;
  assign cic_reset   = !live;
  assign cic_out_clk = live && cnt_q >= rate_cur_q - RATE_W'(2);
  assign busy        = state_q == FLUSH || state_q == SETTLE;
  assign m_valid     = n_q != 2'd0;
  assign m_data      = d0_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb_cic_decim_ctrl: directed and randomized check of cic_decim_ctrl against a behavioural model
module tb_cic_decim_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, rate_wr = 1'b0;
  logic cic_valid = 1'b0, m_ready = 1'b0, ovr_clr = 1'b0;
  logic [15:0] rate = '0;
  logic [23:0] cic_data = '0;
  logic [15:0] rate_cur;
  logic [23:0] m_data;
  logic cic_reset, cic_out_clk, m_valid, busy, overrun;
  int n_chk = 0, n_err = 0;
  bit on, chg, pcv, ovr;
  int flush_left, settle_left, phase, r_cur, pend;
  logic [23:0] hold;
  logic [23:0] q[$];
  always #5 clk = ~clk;
  cic_decim_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rate_wr(rate_wr), .rate(rate),
    .rate_cur(rate_cur), .cic_reset(cic_reset), .cic_out_clk(cic_out_clk),
    .cic_data(cic_data), .cic_valid(cic_valid), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask
  function automatic void m_reset();
    on = 0; chg = 0; pcv = 0; ovr = 0;
    flush_left = 0; settle_left = 0; phase = 0;
    r_cur = 64; pend = 64; hold = '0;
    q.delete();
  endfunction
  function automatic void m_step();
    bit live = on && flush_left == 0;
    bit commit = live && pcv && !cic_valid;
    bit push = live && settle_left == 0 && commit;
    int np = rate_wr ? ((rate < 4) ? 4 : int'(rate)) : pend;
    bit restart;
    bit ovr_n;
    if (!on && rate_wr) r_cur = np;
    if (!enable) begin
      on = 0; flush_left = 0; settle_left = 0; phase = 0; chg = 0;
      q.delete();
      if (ovr_clr) ovr = 0;
    end else begin
      restart = !on || (rate_wr && (flush_left > 0 || settle_left > 0)) ||
                (live && settle_left == 0 && (chg || rate_wr) && phase == r_cur - 1);
      if (q.size() > 0 && m_ready) void'(q.pop_front());
      ovr_n = ovr_clr ? 1'b0 : ovr;
      if (push) begin
        if (q.size() < 2) q.push_back(hold);
        else ovr_n = 1'b1;
      end
      ovr = ovr_n;
      if (restart) begin
        on = 1; flush_left = 8; settle_left = 0; r_cur = np; chg = 0; phase = 0;
      end else if (flush_left > 0) begin
        flush_left--;
        if (flush_left == 0) begin
          settle_left = 4;
          phase = 0;
        end
      end else begin
        if (commit && settle_left > 0) settle_left--;
        phase = (phase + 1) % r_cur;
        chg = chg || rate_wr;
      end
    end
    pend = np;
    pcv = live && cic_valid;
    if (cic_valid) hold = cic_data;
  endfunction
  task automatic compare_all();
    check("cic_reset", cic_reset, !(on && flush_left == 0));
    check("cic_out_clk", cic_out_clk, on && flush_left == 0 && phase >= r_cur - 2);
    check("busy", busy, on && (flush_left > 0 || settle_left > 0));
    check("m_valid", m_valid, q.size() > 0);
    if (q.size() > 0) check("m_data", m_data, q[0]);
    check("overrun", overrun, ovr);
    check("rate_cur", rate_cur, r_cur);
  endtask
  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      m_step();
      @(negedge clk);
      compare_all();
    end
  endtask
  task automatic burst(logic [23:0] d);
    cic_data = d;
    cic_valid = 1'b1;
    cyc(2);
    cic_valid = 1'b0;
    cyc(3);
  endtask
  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset_n = 1'b1;
    enable = 1'b1; rate = 16'd8; rate_wr = 1'b1;
    cyc();
    rate_wr = 1'b0;
    check("t2_busy", busy, 1);
    check("t2_rate", rate_cur, 8);
    check("t2_reset", cic_reset, 1);
    cyc(8);
    check("t2_settle_reset", cic_reset, 0);
    m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) burst(24'(k * 'h11));
    check("t3_data", m_data, 24'h000055);
    check("t3_valid", m_valid, 1);
    check("t3_busy", busy, 0);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    check("t3_drain", m_valid, 0);
    burst(24'hA1); burst(24'hA2); burst(24'hA3);
    check("t4_ovr", overrun, 1);
    check("t4_head", m_data, 24'hA1);
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    check("t4_clr", overrun, 0);
    m_ready = 1'b1;
    cyc();
    check("t4_second", m_data, 24'hA2);
    cyc(2);
    check("t4_empty", m_valid, 0);
    for (int i = 0; i < 20 && phase != 3; i++) cyc();
    rate = 16'd16; rate_wr = 1'b1;
    cyc();
    rate_wr = 1'b0;
    cyc(3);
    check("t5_strobe", cic_out_clk, 1);
    check("t5_rate_old", rate_cur, 8);
    cyc();
    check("t5_flush", cic_reset, 1);
    check("t5_rate_new", rate_cur, 16);
    cyc(8);
    check("t5_settle", cic_reset, 0);
    cyc(40);
    enable = 1'b0;
    cyc();
    rate = 16'd2; rate_wr = 1'b1;
    cyc();
    rate_wr = 1'b0;
    check("t6_clamp", rate_cur, 4);
    enable = 1'b1;
    cyc(21);
    for (int i = 0; i < 3000; i++) begin
      enable   = $urandom_range(0, 299) != 0;
      rate_wr  = $urandom_range(0, 119) == 0;
      rate     = 16'($urandom_range(0, 24));
      m_ready  = 1'($urandom_range(0, 1));
      ovr_clr  = $urandom_range(0, 19) == 0;
      cic_data = 24'($urandom);
      if ($urandom_range(0, 2) == 0) cic_valid = !cic_valid;
      cyc();
    end
    enable = 1'b0; rate_wr = 1'b0; cic_valid = 1'b0; ovr_clr = 1'b0; m_ready = 1'b0;
    cyc();
    enable = 1'b1;
    cyc(9);
    for (int k = 0; k < 5; k++) burst(24'($urandom));
    check("t1_run", busy, 0);
    #2 reset_n = 1'b0;
    #1 m_reset();
    compare_all();
    check("t1_cic_reset", cic_reset, 1);
    check("t1_strobe", cic_out_clk, 0);
    check("t1_valid", m_valid, 0);
    check("t1_data", m_data, 0);
    check("t1_rate", rate_cur, 64);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
